// File: rtl/sd_regbank_bus.sv
// sd_regbank_bus: host-writable control registers and read-only core status
// for the SD controller, on an 8/16/32-bit bus with byte enables.
// Writes are byte-granular; reads are registered (1 clk latency).
// Strobes cmd_start/cmd_int_rst/data_int_rst stay high until the clk cycle
// after the next sd_clk rising edge so the SD clock domain always sees them.
// Optional feature macro: SD_REGBANK_IRQ_EN builds the registered irq output;
// without it irq is tied low.

`ifndef INT_CMD_SIZE
`define INT_CMD_SIZE 5
`endif
`ifndef INT_DATA_SIZE
`define INT_DATA_SIZE 3
`endif
`ifndef CMD_REG_SIZE
`define CMD_REG_SIZE 14
`endif
`ifndef CMD_TIMEOUT_W
`define CMD_TIMEOUT_W 24
`endif
`ifndef DATA_TIMEOUT_W
`define DATA_TIMEOUT_W 24
`endif
`ifndef BLKSIZE_W
`define BLKSIZE_W 12
`endif
`ifndef BLKCNT_W
`define BLKCNT_W 16
`endif
`ifndef RESET_BLOCK_SIZE
`define RESET_BLOCK_SIZE 12'd511
`endif
`ifndef SUPPLY_VOLTAGE_mV
`define SUPPLY_VOLTAGE_mV 16'd3300
`endif

`ifndef SD_ARGUMENT
`define SD_ARGUMENT     7'h00
`endif
`ifndef SD_COMMAND
`define SD_COMMAND      7'h04
`endif
`ifndef SD_RESP0
`define SD_RESP0        7'h08
`endif
`ifndef SD_RESP1
`define SD_RESP1        7'h0C
`endif
`ifndef SD_RESP2
`define SD_RESP2        7'h10
`endif
`ifndef SD_RESP3
`define SD_RESP3        7'h14
`endif
`ifndef SD_DATA_TIMEOUT
`define SD_DATA_TIMEOUT 7'h18
`endif
`ifndef SD_CONTROLLER
`define SD_CONTROLLER   7'h1C
`endif
`ifndef SD_CMD_TIMEOUT
`define SD_CMD_TIMEOUT  7'h20
`endif
`ifndef SD_CLOCK_D
`define SD_CLOCK_D      7'h24
`endif
`ifndef SD_RESET
`define SD_RESET        7'h28
`endif
`ifndef SD_VOLTAGE
`define SD_VOLTAGE      7'h2C
`endif
`ifndef SD_CAPA
`define SD_CAPA         7'h30
`endif
`ifndef SD_CMD_ISR
`define SD_CMD_ISR      7'h34
`endif
`ifndef SD_CMD_ISER
`define SD_CMD_ISER     7'h38
`endif
`ifndef SD_DATA_ISR
`define SD_DATA_ISR     7'h3C
`endif
`ifndef SD_DATA_ISER
`define SD_DATA_ISER    7'h40
`endif
`ifndef SD_BLKSIZE
`define SD_BLKSIZE      7'h44
`endif
`ifndef SD_BLKCNT
`define SD_BLKCNT       7'h48
`endif
`ifndef SD_DST_SRC_ADDR
`define SD_DST_SRC_ADDR 7'h60
`endif

module sd_regbank_bus #(
    parameter int                    DATA_W      = 32,
    parameter int                    BE_W        = DATA_W / 8,
    parameter logic [7:0]            CLKDIV_RST  = 8'd1,
    parameter logic [`BLKSIZE_W-1:0] BLKSIZE_RST = `RESET_BLOCK_SIZE,
    parameter logic [15:0]           VOLTAGE     = `SUPPLY_VOLTAGE_mV,
    parameter logic [15:0]           CAPA        = 16'h0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sd_clk,
    input  logic                          we,
    input  logic                          rd_en,
    input  logic [6:0]                    addr,
    input  logic [BE_W-1:0]               be,
    input  logic [DATA_W-1:0]             data_in,
    output logic [DATA_W-1:0]             data_out,
    output logic                          rd_valid,
    output logic                          cmd_start,
    output logic                          cmd_int_rst,
    output logic                          data_int_rst,
    output logic                          irq,
    input  logic [31:0]                   response_0_reg,
    input  logic [31:0]                   response_1_reg,
    input  logic [31:0]                   response_2_reg,
    input  logic [31:0]                   response_3_reg,
    input  logic [`INT_CMD_SIZE-1:0]      cmd_int_status_reg,
    input  logic [`INT_DATA_SIZE-1:0]     data_int_status_reg,
    output logic [31:0]                   argument_reg,
    output logic [`CMD_REG_SIZE-1:0]      command_reg,
    output logic                          software_reset_reg,
    output logic [`CMD_TIMEOUT_W-1:0]     cmd_timeout_reg,
    output logic [`DATA_TIMEOUT_W-1:0]    data_timeout_reg,
    output logic [`BLKSIZE_W-1:0]         block_size_reg,
    output logic                          controll_setting_reg,
    output logic [`INT_CMD_SIZE-1:0]      cmd_int_enable_reg,
    output logic [7:0]                    clock_divider_reg,
    output logic [`INT_DATA_SIZE-1:0]     data_int_enable_reg,
    output logic [`BLKCNT_W-1:0]          block_count_reg,
    output logic [31:0]                   dma_addr_reg
);

    localparam int CMDW  = `CMD_REG_SIZE;
    localparam int CTOW  = `CMD_TIMEOUT_W;
    localparam int DTOW  = `DATA_TIMEOUT_W;
    localparam int BSW   = `BLKSIZE_W;
    localparam int BCW   = `BLKCNT_W;
    localparam int ICW   = `INT_CMD_SIZE;
    localparam int IDW   = `INT_DATA_SIZE;

    logic [31:0]       argument_q;
    logic [CMDW-1:0]   command_q;
    logic              sw_reset_q;
    logic [CTOW-1:0]   cmd_timeout_q;
    logic [DTOW-1:0]   data_timeout_q;
    logic [BSW-1:0]    block_size_q;
    logic              ctrl_q;
    logic [ICW-1:0]    cmd_ie_q;
    logic [7:0]        clkdiv_q;
    logic [IDW-1:0]    data_ie_q;
    logic [BCW-1:0]    block_count_q;
    logic [31:0]       dma_addr_q;

    logic [DATA_W-1:0] data_out_q, rd_lane;
    logic              rd_valid_q;
    logic              sd_prev_q, sd_rise;
    logic              cmd_start_q, cmd_start_d;
    logic              cmd_int_rst_q, cmd_int_rst_d;
    logic              data_int_rst_q, data_int_rst_d;

    logic [6:0]        reg_addr;
    logic [3:0]        wbe;        // byte enables within the 32-bit register
    logic [31:0]       wdata;      // bus data replicated onto register bytes
    logic              byte0_hit;  // this access maps a lane onto byte 0
    logic [31:0]       rdata32;    // zero-extended value of the selected register
    logic [31:0]       wr_d;       // selected register after byte merge
    logic              req_arg, req_cisr, req_disr;

    assign reg_addr = {addr[6:2], 2'b00};

    // Bus lanes onto register bytes, one mapping per supported width
    generate
        if (DATA_W == 32) begin : g_w32
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^addr[1:0];
            assign wbe       = be & {4{we}};
            assign wdata     = data_in;
            assign byte0_hit = 1'b1;
            assign rd_lane   = rdata32;
        end else if (DATA_W == 16) begin : g_w16
            logic unused_addr_lsb;
            assign unused_addr_lsb = addr[0];
            assign wbe       = addr[1] ? {be & {2{we}}, 2'b00} : {2'b00, be & {2{we}}};
            assign wdata     = {data_in, data_in};
            assign byte0_hit = ~addr[1];
            assign rd_lane   = addr[1] ? rdata32[31:16] : rdata32[15:0];
        end else begin : g_w8
            assign wbe       = 4'(be[0] & we) << addr[1:0];
            assign wdata     = {4{data_in}};
            assign byte0_hit = (addr[1:0] == 2'b00);
            assign rd_lane   = 8'(rdata32 >> {addr[1:0], 3'b000});
        end
    endgenerate

    // Read mux over the whole map; unmapped offsets return 0
    always_comb begin
        rdata32 = 32'h0;
        case (reg_addr)
            `SD_ARGUMENT:     rdata32 = argument_q;
            `SD_COMMAND:      rdata32 = 32'(command_q);
            `SD_RESP0:        rdata32 = response_0_reg;
            `SD_RESP1:        rdata32 = response_1_reg;
            `SD_RESP2:        rdata32 = response_2_reg;
            `SD_RESP3:        rdata32 = response_3_reg;
            `SD_DATA_TIMEOUT: rdata32 = 32'(data_timeout_q);
            `SD_CONTROLLER:   rdata32 = 32'(ctrl_q);
            `SD_CMD_TIMEOUT:  rdata32 = 32'(cmd_timeout_q);
            `SD_CLOCK_D:      rdata32 = 32'(clkdiv_q);
            `SD_RESET:        rdata32 = 32'(sw_reset_q);
            `SD_VOLTAGE:      rdata32 = 32'(VOLTAGE);
            `SD_CAPA:         rdata32 = 32'(CAPA);
            `SD_CMD_ISR:      rdata32 = 32'(cmd_int_status_reg);
            `SD_CMD_ISER:     rdata32 = 32'(cmd_ie_q);
            `SD_DATA_ISR:     rdata32 = 32'(data_int_status_reg);
            `SD_DATA_ISER:    rdata32 = 32'(data_ie_q);
            `SD_BLKSIZE:      rdata32 = 32'(block_size_q);
            `SD_BLKCNT:       rdata32 = 32'(block_count_q);
            `SD_DST_SRC_ADDR: rdata32 = dma_addr_q;
            default:          rdata32 = 32'h0;
        endcase
    end

    // Byte merge of write data into the selected register's current value;
    // each register keeps only its own low bits, so overflow bits drop out
    always_comb begin
        wr_d = rdata32;
        for (int i = 0; i < 4; i++) begin
            if (wbe[i]) wr_d[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // Strobe requests and their set-dominant hold-until-sd_rise update
    always_comb begin
        req_arg        = we & byte0_hit & (reg_addr == `SD_ARGUMENT);
        req_cisr       = we & byte0_hit & (reg_addr == `SD_CMD_ISR);
        req_disr       = we & byte0_hit & (reg_addr == `SD_DATA_ISR);
        sd_rise        = ~sd_prev_q & sd_clk;
        cmd_start_d    = req_arg  | (cmd_start_q    & ~sd_rise);
        cmd_int_rst_d  = req_cisr | (cmd_int_rst_q  & ~sd_rise);
        data_int_rst_d = req_disr | (data_int_rst_q & ~sd_rise);
    end

    // Host-writable control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            argument_q     <= '0;
            command_q      <= '0;
            sw_reset_q     <= 1'b0;
            cmd_timeout_q  <= '0;
            data_timeout_q <= '0;
            block_size_q   <= BLKSIZE_RST;
            ctrl_q         <= 1'b0;
            cmd_ie_q       <= '0;
            clkdiv_q       <= CLKDIV_RST;
            data_ie_q      <= '0;
            block_count_q  <= '0;
            dma_addr_q     <= '0;
        end else if (we) begin
            case (reg_addr)
                `SD_ARGUMENT:     argument_q     <= wr_d;
                `SD_COMMAND:      command_q      <= wr_d[CMDW-1:0];
                `SD_RESET:        sw_reset_q     <= wr_d[0];
                `SD_CMD_TIMEOUT:  cmd_timeout_q  <= wr_d[CTOW-1:0];
                `SD_DATA_TIMEOUT: data_timeout_q <= wr_d[DTOW-1:0];
                `SD_BLKSIZE:      block_size_q   <= wr_d[BSW-1:0];
                `SD_CONTROLLER:   ctrl_q         <= wr_d[0];
                `SD_CMD_ISER:     cmd_ie_q       <= wr_d[ICW-1:0];
                `SD_CLOCK_D:      clkdiv_q       <= wr_d[7:0];
                `SD_DATA_ISER:    data_ie_q      <= wr_d[IDW-1:0];
                `SD_BLKCNT:       block_count_q  <= wr_d[BCW-1:0];
                `SD_DST_SRC_ADDR: dma_addr_q     <= wr_d;
                default: ;
            endcase
        end
    end

    // Registered read port; data_out holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) data_out_q <= rd_lane;
        end
    end

    // sd_clk edge history and the three SD-domain strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_prev_q      <= 1'b0;
            cmd_start_q    <= 1'b0;
            cmd_int_rst_q  <= 1'b0;
            data_int_rst_q <= 1'b0;
        end else begin
            sd_prev_q      <= sd_clk;
            cmd_start_q    <= cmd_start_d;
            cmd_int_rst_q  <= cmd_int_rst_d;
            data_int_rst_q <= data_int_rst_d;
        end
    end

`ifdef SD_REGBANK_IRQ_EN
    logic irq_q, irq_d;

    // A status-clear request masks irq for one cycle so the host does not
    // see the interrupt it is acknowledging before status drops
    always_comb begin
        irq_d = (|(cmd_int_status_reg & cmd_ie_q)) | (|(data_int_status_reg & data_ie_q));
        if (req_cisr | req_disr) irq_d = 1'b0;
    end

    // Registered interrupt line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign data_out             = data_out_q;
    assign rd_valid             = rd_valid_q;
    assign cmd_start            = cmd_start_q;
    assign cmd_int_rst          = cmd_int_rst_q;
    assign data_int_rst         = data_int_rst_q;
    assign argument_reg         = argument_q;
    assign command_reg          = command_q;
    assign software_reset_reg   = sw_reset_q;
    assign cmd_timeout_reg      = cmd_timeout_q;
    assign data_timeout_reg     = data_timeout_q;
    assign block_size_reg       = block_size_q;
    assign controll_setting_reg = ctrl_q;
    assign cmd_int_enable_reg   = cmd_ie_q;
    assign clock_divider_reg    = clkdiv_q;
    assign data_int_enable_reg  = data_ie_q;
    assign block_count_reg      = block_count_q;
    assign dma_addr_reg         = dma_addr_q;

endmodule

// File: tb/tb_sd_regbank_bus.sv
// Bench for sd_regbank_bus: three instances (32/16/8-bit buses) against a
// byte-level model of the register map, plus hand-computed expectations.
module tb_sd_regbank_bus;

  localparam int NB  [3]  = '{4, 2, 1};
  // offsets of the 12 register outputs, in the order of ro[k][j]
  localparam int OFF [12] = '{'h00, 'h04, 'h28, 'h20, 'h18, 'h44,
                              'h1c, 'h38, 'h24, 'h40, 'h48, 'h60};
`ifdef SD_REGBANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, sd_clk;
  logic        we_a [3], rd_a [3];
  logic [6:0]  addr_a [3];
  logic [3:0]  be_a [3];
  logic [31:0] din_a [3];
  logic [31:0] r0, r1, r2, r3;
  logic [4:0]  cis;
  logic [2:0]  dis;

  logic [31:0] dout_a [3];
  logic        rv_a [3], cs_a [3], ci_a [3], di_a [3], irq_a [3];
  logic [31:0] ro [3][12];

  int n_chk = 0, n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    logic [W-1:0] dout;
    logic rv, cs, ci, di, iq, swr, ctl;
    logic [31:0] arg, dma;
    logic [13:0] cmd;
    logic [23:0] cto, dto;
    logic [11:0] bsz;
    logic [4:0]  cie;
    logic [7:0]  cdv;
    logic [2:0]  die;
    logic [15:0] bct;
    sd_regbank_bus #(.DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .sd_clk(sd_clk), .we(we_a[g]), .rd_en(rd_a[g]),
      .addr(addr_a[g]), .be(be_a[g][W/8-1:0]), .data_in(din_a[g][W-1:0]),
      .data_out(dout), .rd_valid(rv), .cmd_start(cs), .cmd_int_rst(ci),
      .data_int_rst(di), .irq(iq),
      .response_0_reg(r0), .response_1_reg(r1), .response_2_reg(r2), .response_3_reg(r3),
      .cmd_int_status_reg(cis), .data_int_status_reg(dis),
      .argument_reg(arg), .command_reg(cmd), .software_reset_reg(swr),
      .cmd_timeout_reg(cto), .data_timeout_reg(dto), .block_size_reg(bsz),
      .controll_setting_reg(ctl), .cmd_int_enable_reg(cie), .clock_divider_reg(cdv),
      .data_int_enable_reg(die), .block_count_reg(bct), .dma_addr_reg(dma));
    assign dout_a[g] = 32'(dout);
    assign rv_a[g] = rv;  assign cs_a[g] = cs;  assign ci_a[g] = ci;
    assign di_a[g] = di;  assign irq_a[g] = iq;
    assign ro[g][0] = arg;        assign ro[g][1] = 32'(cmd);  assign ro[g][2] = 32'(swr);
    assign ro[g][3] = 32'(cto);   assign ro[g][4] = 32'(dto);  assign ro[g][5] = 32'(bsz);
    assign ro[g][6] = 32'(ctl);   assign ro[g][7] = 32'(cie);  assign ro[g][8] = 32'(cdv);
    assign ro[g][9] = 32'(die);   assign ro[g][10] = 32'(bct); assign ro[g][11] = dma;
  end

  // ---------------- model ----------------
  logic [31:0] mreg [3][32];
  logic [31:0] m_dout [3];
  logic        m_rv [3], m_cs [3], m_ci [3], m_di [3], m_irq [3];
  logic        m_prev;

  function automatic logic [31:0] wmask(int off);
    case (off)
      'h00, 'h60: return 32'hFFFF_FFFF;
      'h04:       return 32'h3FFF;
      'h28, 'h1c: return 32'h1;
      'h20, 'h18: return 32'h00FF_FFFF;
      'h44:       return 32'hFFF;
      'h38:       return 32'h1F;
      'h24:       return 32'hFF;
      'h40:       return 32'h7;
      'h48:       return 32'hFFFF;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rdval(int k, int off);
    if (wmask(off) != 0) return mreg[k][off/4];
    case (off)
      'h08: return r0;
      'h0c: return r1;
      'h10: return r2;
      'h14: return r3;
      'h2c: return 32'd3300;
      'h34: return {27'b0, cis};
      'h3c: return {29'b0, dis};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int r = 0; r < 32; r++) mreg[k][r] <= 32'h0;
        mreg[k]['h24/4] <= 32'd1;
        mreg[k]['h44/4] <= 32'd511;
        m_dout[k] <= 0; m_rv[k] <= 0; m_cs[k] <= 0; m_ci[k] <= 0; m_di[k] <= 0; m_irq[k] <= 0;
      end
      m_prev <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        automatic int base = int'(addr_a[k][1:0]) & ~(NB[k] - 1);
        automatic int off  = int'({addr_a[k][6:2], 2'b00});
        automatic logic [31:0] msk = wmask(off);
        automatic logic [31:0] lmask = (NB[k] == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*NB[k])) - 1);
        automatic logic rise  = !m_prev && sd_clk;
        automatic logic req_a = we_a[k] && base == 0 && off == 'h00;
        automatic logic req_c = we_a[k] && base == 0 && off == 'h34;
        automatic logic req_d = we_a[k] && base == 0 && off == 'h3c;
        m_rv[k] <= rd_a[k];
        if (rd_a[k]) m_dout[k] <= (rdval(k, off) >> (8*base)) & lmask;
        if (we_a[k])
          for (int i = 0; i < NB[k]; i++)
            if (be_a[k][i])
              mreg[k][off/4][8*(base+i) +: 8] <= din_a[k][8*i +: 8] & msk[8*(base+i) +: 8];
        m_cs[k] <= req_a || (m_cs[k] && !rise);
        m_ci[k] <= req_c || (m_ci[k] && !rise);
        m_di[k] <= req_d || (m_di[k] && !rise);
        m_irq[k] <= IRQ_ON && !(req_c || req_d) &&
                    ((|(cis & mreg[k]['h38/4][4:0])) || (|(dis & mreg[k]['h40/4][2:0])));
      end
      m_prev <= sd_clk;
    end
  end

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("rd_valid", k, 32'(rv_a[k]), 32'(m_rv[k]));
        chk("data_out", k, dout_a[k], m_dout[k]);
        chk("cmd_start", k, 32'(cs_a[k]), 32'(m_cs[k]));
        chk("cmd_int_rst", k, 32'(ci_a[k]), 32'(m_ci[k]));
        chk("data_int_rst", k, 32'(di_a[k]), 32'(m_di[k]));
        chk("irq", k, 32'(irq_a[k]), 32'(m_irq[k]));
        for (int j = 0; j < 12; j++)
          chk($sformatf("reg@%0h", OFF[j]), k, ro[k][j], mreg[k][OFF[j]/4]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(int k, logic [6:0] a, logic [3:0] b, logic [31:0] d);
    we_a[k] = 1'b1; addr_a[k] = a; be_a[k] = b; din_a[k] = d;
    cyc(1);
    we_a[k] = 1'b0;
  endtask

  task automatic rd(int k, logic [6:0] a);
    rd_a[k] = 1'b1; addr_a[k] = a;
    cyc(1);
    rd_a[k] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sd_clk = 1'b0;
    r0 = 32'hDEADBEEF; r1 = 32'h01020304; r2 = 32'h0; r3 = 32'hCAFEF00D;
    cis = '0; dis = '0;
    for (int k = 0; k < 3; k++) begin
      we_a[k] = 0; rd_a[k] = 0; addr_a[k] = '0; be_a[k] = '0; din_a[k] = '0;
    end
    cyc(1);
    chk_en = 1;
    cyc(1);
    // reset state
    chk("rst clock_div", 0, ro[0][8], 32'd1);
    chk("rst block_size", 2, ro[2][5], 32'd511);
    chk("rst rd_valid", 1, 32'(rv_a[1]), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // 8-bit bus: argument built byte by byte
    wr(2, 7'h00, 4'h1, 32'h78);
    chk("w8 cmd_start rise", 2, 32'(cs_a[2]), 32'd1);
    wr(2, 7'h01, 4'h1, 32'h56);
    wr(2, 7'h02, 4'h1, 32'h34);
    wr(2, 7'h03, 4'h1, 32'h12);
    chk("w8 argument", 2, ro[2][0], 32'h12345678);
    chk("w8 cmd_start held", 2, 32'(cs_a[2]), 32'd1);
    sd_clk = 1'b1; cyc(1);
    chk("w8 cmd_start fall", 2, 32'(cs_a[2]), 32'd0);
    sd_clk = 1'b0; cyc(1);

    // 32-bit bus: partial byte enables on the DMA address
    wr(0, 7'h60, 4'b0101, 32'hAABBCCDD);
    chk("w32 dma be", 0, ro[0][11], 32'h00BB00DD);

    // cmd_int_rst held through a long sd_clk low phase
    wr(0, 7'h34, 4'hF, 32'h0);
    repeat (10) begin
      chk("cisr hold", 0, 32'(ci_a[0]), 32'd1);
      cyc(1);
    end
    sd_clk = 1'b1; cyc(1);
    chk("cisr clear", 0, 32'(ci_a[0]), 32'd0);
    sd_clk = 1'b0; cyc(1);

    // request in the same cycle as sd_rise: set wins
    sd_clk = 1'b1;
    wr(0, 7'h3C, 4'h1, 32'h0);
    chk("set wins", 0, 32'(di_a[0]), 32'd1);
    cyc(1);
    chk("no rise keeps", 0, 32'(di_a[0]), 32'd1);
    sd_clk = 1'b0; cyc(1);
    sd_clk = 1'b1; cyc(1);
    chk("disr clear", 0, 32'(di_a[0]), 32'd0);
    sd_clk = 1'b0; cyc(1);

    // 16-bit bus reads
    rd(1, 7'h0A);
    chk("w16 resp0 hi", 1, dout_a[1], 32'h0000DEAD);
    chk("w16 rd_valid", 1, 32'(rv_a[1]), 32'd1);
    rd(1, 7'h7C);
    chk("w16 unmapped", 1, dout_a[1], 32'h0);
    cyc(1);
    chk("rd_valid drop", 1, 32'(rv_a[1]), 32'd0);
    // width truncation: upper half of command does not exist
    wr(1, 7'h06, 4'h3, 32'hFFFF);
    wr(1, 7'h04, 4'h3, 32'hFFFF);
    chk("w16 command trunc", 1, ro[1][1], 32'h3FFF);
    rd(1, 7'h06);
    chk("w16 command hi", 1, dout_a[1], 32'h0);
    // 8-bit read of voltage high byte
    rd(2, 7'h2D);
    chk("w8 voltage hi", 2, dout_a[2], 32'h0C);
    // write to read-only response is ignored
    wr(0, 7'h08, 4'hF, 32'h11111111);
    rd(0, 7'h08);
    chk("w32 resp0 ro", 0, dout_a[0], 32'hDEADBEEF);

    // read and write of the same register: read sees old value
    wr(0, 7'h18, 4'hF, 32'h11223344);
    we_a[0] = 1; rd_a[0] = 1; addr_a[0] = 7'h18; be_a[0] = 4'hF; din_a[0] = 32'h55667788;
    cyc(1);
    we_a[0] = 0; rd_a[0] = 0;
    chk("rw old value", 0, dout_a[0], 32'h00223344);
    chk("rw new reg", 0, ro[0][4], 32'h00667788);
    wr(0, 7'h24, 4'h1, 32'h2A);

    // asynchronous reset while strobe and rd_valid are high
    rd_a[1] = 1; addr_a[1] = 7'h00;
    wr(0, 7'h00, 4'hF, 32'h1);
    rd_a[1] = 0;
    chk("pre-rst cmd_start", 0, 32'(cs_a[0]), 32'd1);
    chk("pre-rst rd_valid", 1, 32'(rv_a[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst cmd_start", 0, 32'(cs_a[0]), 32'd0);
    chk("rst rd_valid", 1, 32'(rv_a[1]), 32'd0);
    chk("rst clkdiv", 0, ro[0][8], 32'd1);
    chk("rst blksize", 0, ro[0][5], 32'd511);
    @(posedge clk); #2 rst_n = 1'b1;
    cyc(1);

    // interrupt combine and one-cycle mask on status clear
    wr(0, 7'h38, 4'hF, 32'h1);
    cis = 5'b00001;
    cyc(1);
    chk("irq set", 0, 32'(irq_a[0]), 32'(IRQ_ON));
    wr(0, 7'h34, 4'h1, 32'h0);
    chk("irq masked", 0, 32'(irq_a[0]), 32'd0);
    cyc(1);
    chk("irq back", 0, 32'(irq_a[0]), 32'(IRQ_ON));
    cis = 5'b0; dis = 3'b100;
    wr(1, 7'h40, 4'h3, 32'h4);
    cyc(2);
    chk("irq data", 1, 32'(irq_a[1]), 32'(IRQ_ON));
    dis = 3'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_regbank_bus.md
# sd_regbank_bus

Parametrised register bank for the SD card controller with a configurable bus width (8/16/32 bits) and byte enables. It holds all host-writable control registers and returns read-only core status on a registered read port. It generates the cmd_start / cmd_int_rst / data_int_rst strobes, which are held until the next sd_clk rising edge. It can also combine enabled interrupt sources into one registered irq line. It sits between the host bus adapter and the SD command/data cores, and uses register offsets and field widths from sd_defines.h.

## Interface
Parameters:
- DATA_W, 32: bus data width; legal values are 8, 16 and 32.
- BE_W, DATA_W/8: width of the byte-enable bus (derived).
- CLKDIV_RST, 1: reset value of clock_divider_reg.
- BLKSIZE_RST, `RESET_BLOCK_SIZE: reset value of block_size_reg.
- VOLTAGE, `SUPPLY_VOLTAGE_mV: constant returned at `voltage.
- CAPA, 16'h0000: constant returned at `capa.

Ports:
- clk in 1: system clock; the block uses this one clock only.
- rst_n in 1: asynchronous, active-low reset.
- sd_clk in 1: divided SD clock, sampled as data (edge detect only).
- we in 1: write request.
- rd_en in 1: read request.
- addr in 7: byte address.
- be in BE_W: byte enables.
- data_in in DATA_W: write data.
- data_out out DATA_W: read data (registered).
- rd_valid out 1: data_out is valid.
- cmd_start, cmd_int_rst, data_int_rst out 1 each: strobes to the SD clock domain.
- irq out 1: combined interrupt.
- response_0..3_reg in 32 each; cmd_int_status_reg in `INT_CMD_SIZE; data_int_status_reg in `INT_DATA_SIZE.
- argument_reg out 32; command_reg out `CMD_REG_SIZE; software_reset_reg out 1; cmd_timeout_reg out `CMD_TIMEOUT_W; data_timeout_reg out `DATA_TIMEOUT_W; block_size_reg out `BLKSIZE_W; controll_setting_reg out 1; cmd_int_enable_reg out `INT_CMD_SIZE; clock_divider_reg out 8; data_int_enable_reg out `INT_DATA_SIZE; block_count_reg out `BLKCNT_W; dma_addr_reg out 32.

## Operation
- Register select: reg_addr = {addr[6:2], 2'b00}.
- Lane mapping, DATA_W=32: lane i maps to byte i; addr[1:0] is ignored.
- Lane mapping, DATA_W=16: lane i maps to byte {addr[1], i}.
- Lane mapping, DATA_W=8: lane 0 maps to byte addr[1:0].
- A byte is written only when its be bit is set and we=1.
- Register bits beyond the register width are dropped on write and read as 0.
- Writes to read-only or unmapped offsets are ignored. Reads of unmapped offsets return 0.
- Strobe requests are raised by a write cycle whose mapped lanes include byte 0 of:
  - `argument -> cmd_start;
  - `cmd_isr -> cmd_int_rst;
  - `data_isr -> data_int_rst.
- Edge detect: sd_prev <= sd_clk every cycle; sd_rise = ~sd_prev & sd_clk.
- Each strobe is set by its request and cleared in the cycle after sd_rise. It is therefore high across at least one sd_clk rising edge.
- If a request and sd_rise occur in the same cycle, the set wins.
- A request arriving while a strobe is already high keeps it high; requests are not counted.
- Read: when rd_en=1, data_out captures the selected register lane(s) and rd_valid=1 on the next cycle. When rd_en=0, rd_valid=0 and data_out holds its value.
- If we and rd_en hit the same register in the same cycle, the read returns the pre-write value.

## Timing
- Register writes are visible on their outputs 1 clk after the we cycle.
- Read latency is 1 clk.
- cmd_start rises 1 clk after the write. It falls 1 clk after the first sd_rise that occurs at or after that rise.
- irq is registered and asserts 1 clk after an enabled status bit goes high.
- Reset values:
  - all register outputs are 0, except clock_divider_reg=CLKDIV_RST and block_size_reg=BLKSIZE_RST;
  - data_out=0, rd_valid=0;
  - strobes=0, irq=0, sd_prev=0.
- An rst_n assertion mid-operation immediately clears pending strobes and rd_valid, with no further sd_clk dependency.

## Configuration
- SD_REGBANK_IRQ_EN defined:
  - irq <= |(cmd_int_status_reg & cmd_int_enable_reg) | |(data_int_status_reg & data_int_enable_reg);
  - irq is forced to 0 in the cycle after a cmd_int_rst or data_int_rst request. It then re-evaluates from the status inputs.
- SD_REGBANK_IRQ_EN undefined: irq is tied to 0 and no irq logic is generated. The enable registers remain readable and writable.

## Test plan
- DATA_W=8:
  - write bytes 0x78, 0x56, 0x34, 0x12 to addr `argument+0..3 -> argument_reg=32'h12345678;
  - cmd_start rises after the first byte and falls after the next sd_rise.
- DATA_W=32, write 32'hAABBCCDD to `dst_src_addr with be=4'b0101 from reset -> dma_addr_reg=32'h00BB00DD.
- Hold sd_clk low for 10 clk after a write to `cmd_isr -> cmd_int_rst stays high for all 10 clk; it clears 1 clk after sd_clk rises.
- Assert rst_n low while cmd_start=1 -> cmd_start=0 immediately; clock_divider_reg=1 and block_size_reg=`RESET_BLOCK_SIZE.
- DATA_W=16:
  - rd_en at addr `resp0+2 with response_0_reg=32'hDEADBEEF -> data_out=16'hDEAD with rd_valid the next cycle;
  - rd_en at unmapped offset 0x7C -> data_out=0.
- IRQ_EN, cmd_int_enable_reg=1, cmd_int_status_reg[0] driven to 1 -> irq=1 on the next clk; a write to `cmd_isr gives irq=0 for one cycle.
